imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: receives a byte stream (from UART/debug bridge) and
//  writes 32-bit little-endian words into the imem write port while holding the CPU off.
//  After the payload, it fills every remaining word up to DEPTH with HALT_WORD, so an unloaded
//  fetch executes halt (beq x0,x0,0). Sits between the byte-stream receiver and imem/core reset.
// PARAMETERS
//  DEPTH      256           words in imem; legal word count is 0..DEPTH
//  BASE_ADDR  32'h0         byte address of word 0
//  HALT_WORD  32'h00000063  fill word for unloaded locations
//  TIMEOUT    1000000       idle cycles allowed between bytes before error; 0 = no timeout
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  byte_valid  in   1   byte_data valid
//  byte_data   in   8   stream byte
//  byte_ready  out  1   loader accepts a byte; transfer = byte_valid & byte_ready
//  wr_en       out  1   imem write strobe, one cycle per word
//  wr_addr     out  32  byte address, word aligned: BASE_ADDR + 4*index
//  wr_data     out  32  word to write
//  cpu_hold    out  1   keep core in reset / stalled while high
//  done        out  1   level: load finished OK
//  error       out  1   level: load aborted
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-load aborts immediately; partial
//    imem contents are not cleaned up.
//  - Frame: HDR0 = count[7:0], HDR1 = count[15:8], then 4*count payload bytes, LSB first.
//  - States: IDLE -start-> HDR0 -> HDR1 -> DATA -> [CSUM] -> FILL -> DONE. Any error -> ERR.
//    start in DONE/ERR clears done/error and goes to HDR0; start elsewhere is ignored.
//  - byte_ready = 1 only in HDR0, HDR1, DATA, CSUM; 0 in IDLE, FILL, DONE, ERR.
//  - HDR1 accept: count > DEPTH -> ERR; count == 0 -> FILL; else -> DATA.
//  - DATA: bytes shift into a 32-bit assembler. The 4th byte, accepted in cycle N, yields
//    wr_en=1 in cycle N+1 with wr_data = {b3,b2,b1,b0} and wr_addr for the current index.
//    The index then increments. Back-to-back bytes are accepted every cycle (no stall).
//  - The last word's write is issued in the FILL entry cycle, and filling starts after it.
//  - FILL: one write per cycle, wr_data = HALT_WORD, index count..DEPTH-1, then DONE.
//    If count == DEPTH, FILL issues no halt writes and goes to DONE in the next cycle.
//  - cpu_hold = 1 in HDR0..FILL; 0 in IDLE, DONE, ERR. done = 1 only in DONE.
//    error = 1 only in ERR. wr_en = 0 outside DATA/FILL write cycles.
//  - Timeout: in HDR0/HDR1/DATA/CSUM, a counter counts cycles with no transfer and is
//    cleared by each transfer. Reaching TIMEOUT -> ERR. TIMEOUT=0 disables the counter.
//  - wr_addr arithmetic: 32-bit, index zero-extended, shifted left 2, no wrap within DEPTH.
//  - Simultaneous: a transfer in the same cycle the timeout expires counts as a transfer,
//    so no error is raised.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//    - After the last payload byte, state CSUM accepts one byte.
//    - This byte must equal the XOR of all payload bytes (header excluded).
//    - Match -> FILL. Mismatch -> ERR, and the halt fill is skipped.
//    - Payload words are already written when the mismatch is found; error flags the image.
//  Undefined: no CSUM state; DATA -> FILL directly; the frame has no trailing byte.
// TESTING
//  - Reset: rst_n=0 mid-DATA -> next edge: byte_ready=0, cpu_hold=0, wr_en=0, done=0, error=0.
//  - start; bytes 02 00 13 00 00 00 93 00 10 00, one per cycle -> two writes:
//    addr 0 data 00000013; addr 4 data 00100093.
//    Then 254 writes of 00000063 at addr 8..3FC; done=1; cpu_hold=0.
//  - Header 00 00 -> 256 halt writes at 0..3FC, then done. Header 01 01 (257) -> error=1,
//    byte_ready=0, no wr_en.
//  - TIMEOUT=16, header only then silence -> error=1 on cycle 16 after the last byte.
//    Then a start pulse -> error=0 and state HDR0.
//  - byte_valid toggled 1/0 randomly during the payload -> the same writes as the
//    back-to-back case; start pulses mid-load are ignored.
//  - CHECKSUM_EN, count 1, payload 11 22 33 44:
//    csum 44 -> write, 255 fills, done. csum 45 -> error=1, no fill writes.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle used by imem_loader.
// master is the loader; slave is the stream source together with the imem write port.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Imem loader: framed byte stream -> 32-bit little-endian imem writes, then HALT_WORD fill to DEPTH.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, core released
// HDR0  | expect count[7:0]
// HDR1  | expect count[15:8], range check
// DATA  | assembling payload words, one write per 4 bytes
// CSUM  | expect XOR of payload bytes (checksum build only)
// FILL  | writing HALT_WORD into the remaining words
// DONE  | image loaded, core released
// ERR   | load aborted, core released
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] HALT_WORD = 32'h0000_0063,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_FILL, S_DONE, S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);
    localparam logic [31:0] TMO_LOAD = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] count;
    logic [16:0] idx;
    logic [1:0]  lane;
    logic [23:0] asm_q;
    logic [31:0] tmo;
    logic        waiting;
    logic        xfer;
    logic        last_word;
    logic [15:0] hdr_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign waiting        = (state == S_HDR0) || (state == S_HDR1) ||
                            (state == S_DATA) || (state == S_CSUM);
    assign bus.byte_ready = waiting;
    assign xfer           = bus.byte_valid & waiting;
    assign hdr_count      = {bus.byte_data, count[7:0]};
    assign last_word      = (idx + 17'd1) == {1'b0, count};
    assign cpu_hold       = waiting || (state == S_FILL);
    assign done           = (state == S_DONE);
    assign error          = (state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            count       <= '0;
            idx         <= '0;
            lane        <= '0;
            asm_q       <= '0;
            tmo         <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state <= S_HDR0;
                        idx   <= '0;
                        lane  <= '0;
                        tmo   <= TMO_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                S_HDR0: begin
                    if (xfer) begin
                        count[7:0] <= bus.byte_data;
                        state      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        count[15:8] <= bus.byte_data;
                        if ({1'b0, hdr_count} > DEPTH_W) state <= S_ERR;
                        else if (hdr_count == 16'd0)     state <= S_FILL;
                        else                             state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        lane <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.byte_data;
`endif
                        // 4th byte completes the word; earlier bytes shift in from the top
                        if (lane == 2'd3) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= BASE_ADDR + {13'd0, idx, 2'b00};
                            bus.wr_data <= {bus.byte_data, asm_q};
                            idx         <= idx + 17'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_FILL;
`endif
                            end
                        end else begin
                            asm_q <= {bus.byte_data, asm_q[23:8]};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) state <= (bus.byte_data == csum) ? S_FILL : S_ERR;
                end
`endif
                S_FILL: begin
                    if (idx < DEPTH_W) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= BASE_ADDR + {13'd0, idx, 2'b00};
                        bus.wr_data <= HALT_WORD;
                        idx         <= idx + 17'd1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // a transfer in the expiry cycle wins over the timeout
            if (waiting) begin
                if (xfer) begin
                    tmo <= TMO_LOAD;
                end else if (TIMEOUT != 0) begin
                    if (tmo == 32'd0) state <= S_ERR;
                    else              tmo   <= tmo - 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, halt fill, depth limits, timeout, gaps, checksum.
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int TMO   = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int FULL_END_LAT = 2;
`else
    localparam int FULL_END_LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH(DEPTH), .BASE_ADDR(32'h0), .HALT_WORD(32'h0000_0063), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
            wq_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cyc  = 0;
    int w0_acc   = 0;
    int end_cyc  = 0;

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   k;
        rdy = 1'b0;
        k   = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!rdy && k < 40) begin
            @(negedge clk);
            rdy = bus.byte_ready;
            @(posedge clk);
            k++;
        end
        #1;
        bus.byte_valid = 1'b0;
        acc_cyc = cyc;
        if (!rdy) begin
            n_checks++;
            $display("FAIL send_byte: byte_ready stayed %b for byte %h, required 1", rdy, b);
        end
    endtask

    task automatic send_frame(input logic [15:0] cnt, input logic [7:0] pl[$],
                              input bit gaps, input logic [7:0] csum_flip);
        logic [7:0] x;
        x = 8'h00;
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        foreach (pl[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                if (i == 3 || i == 6) pulse_start();
            end
            send_byte(pl[i]);
            if (i == 3) w0_acc = acc_cyc;
            x = x ^ pl[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (cnt != 16'd0) send_byte(x ^ csum_flip);
`endif
    endtask

    task automatic wait_end(input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) ok = 1'b1;
        end
        end_cyc = cyc;
        @(posedge clk); #1;
    endtask

    // mismatches of the captured writes against payload words followed by halt fill
    function automatic int img_bad(input logic [31:0] words[$]);
        int          bad;
        logic [31:0] e;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            e = (i < words.size()) ? words[i] : 32'h0000_0063;
            if (i >= wq_data.size()) bad++;
            else if (wq_data[i] !== e || wq_addr[i] !== 32'(4 * i)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        logic [7:0] pl[$];
        #12;
        n_checks++;
        if ({bus.byte_ready, cpu_hold, bus.wr_en, done, error} !== 5'b0)
            $display("FAIL reset_init: outputs %b, required 00000",
                     {bus.byte_ready, cpu_hold, bus.wr_en, done, error});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        pl = '{8'h13, 8'h00};
        send_frame(16'd2, pl, 1'b0, 8'h00);
        n_checks++;
        if (cpu_hold !== 1'b1) $display("FAIL hold_in_data: cpu_hold %b, required 1", cpu_hold);
        else n_pass++;
        n_checks++;
        if (bus.byte_ready !== 1'b1) $display("FAIL ready_in_data: byte_ready %b, required 1", bus.byte_ready);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.byte_ready !== 1'b0) $display("FAIL rst_ready: byte_ready %b, required 0", bus.byte_ready);
        else n_pass++;
        n_checks++;
        if (cpu_hold !== 1'b0) $display("FAIL rst_hold: cpu_hold %b, required 0", cpu_hold);
        else n_pass++;
        n_checks++;
        if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en: wr_en %b, required 0", bus.wr_en);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_flags: done %b error %b, required 0 0", done, error);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_two_words(input bit gaps);
        logic [7:0]  pl[$];
        logic [31:0] words[$];
        bit          ok;
        clear_writes();
        pulse_start();
        pl    = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        words = '{32'h0000_0013, 32'h0010_0093};
        send_frame(16'd2, pl, gaps, 8'h00);
        if (gaps) pulse_start();
        wait_end(600, ok);
        n_checks++;
        if (!ok) $display("FAIL two_words_end: no done/error within bound (gaps=%0d)", gaps);
        else n_pass++;
        n_checks++;
        if (wq_data.size() !== DEPTH) $display("FAIL two_words_count: %0d writes, required %0d", wq_data.size(), DEPTH);
        else n_pass++;
        n_checks++;
        if (img_bad(words) !== 0) $display("FAIL two_words_image: %0d bad words, required 0", img_bad(words));
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0)
            $display("FAIL two_words_flags: done %b hold %b error %b, required 1 0 0", done, cpu_hold, error);
        else n_pass++;
        if (!gaps) begin
            n_checks++;
            if (wq_data.size() < 2 || wq_addr[1] !== 32'h4 || wq_data[1] !== 32'h0010_0093)
                $display("FAIL word1: addr %h data %h, required 00000004 00100093",
                         wq_data.size() > 1 ? wq_addr[1] : 32'hx, wq_data.size() > 1 ? wq_data[1] : 32'hx);
            else n_pass++;
            n_checks++;
            if (wq_cyc.size() < 1 || wq_cyc[0] !== w0_acc)
                $display("FAIL word0_latency: write cycle %0d, required %0d",
                         wq_cyc.size() > 0 ? wq_cyc[0] : -1, w0_acc);
            else n_pass++;
            n_checks++;
            if (bus.byte_ready !== 1'b0) $display("FAIL done_ready: byte_ready %b, required 0", bus.byte_ready);
            else n_pass++;
        end
    endtask

    task automatic test_empty();
        logic [7:0]  pl[$];
        logic [31:0] words[$];
        bit          ok;
        clear_writes();
        pulse_start();
        pl.delete();
        words.delete();
        send_frame(16'd0, pl, 1'b0, 8'h00);
        wait_end(600, ok);
        n_checks++;
        if (!ok || done !== 1'b1) $display("FAIL empty_done: done %b, required 1", done);
        else n_pass++;
        n_checks++;
        if (wq_data.size() !== DEPTH || img_bad(words) !== 0)
            $display("FAIL empty_image: %0d writes %0d bad, required %0d writes 0 bad", wq_data.size(), img_bad(words), DEPTH);
        else n_pass++;
        n_checks++;
        if (wq_cyc.size() > 0 && end_cyc !== wq_cyc[wq_cyc.size() - 1] + 1)
            $display("FAIL empty_done_cycle: done at %0d, required %0d", end_cyc, wq_cyc[wq_cyc.size() - 1] + 1);
        else n_pass++;
    endtask

    task automatic test_full();
        logic [7:0]  pl[$];
        logic [31:0] words[$];
        logic [31:0] w;
        bit          ok;
        clear_writes();
        for (int i = 0; i < DEPTH; i++) begin
            w = (32'(i) * 32'h0101_0101) ^ 32'h5A3C_0F96;
            words.push_back(w);
            pl.push_back(w[7:0]);
            pl.push_back(w[15:8]);
            pl.push_back(w[23:16]);
            pl.push_back(w[31:24]);
        end
        pulse_start();
        send_frame(16'(DEPTH), pl, 1'b0, 8'h00);
        wait_end(100, ok);
        n_checks++;
        if (!ok || done !== 1'b1) $display("FAIL full_done: done %b error %b, required 1 0", done, error);
        else n_pass++;
        n_checks++;
        if (wq_data.size() !== DEPTH || img_bad(words) !== 0)
            $display("FAIL full_image: %0d writes %0d bad, required %0d writes 0 bad", wq_data.size(), img_bad(words), DEPTH);
        else n_pass++;
        n_checks++;
        if (wq_cyc.size() == 0 || end_cyc !== wq_cyc[wq_cyc.size() - 1] + FULL_END_LAT)
            $display("FAIL full_done_cycle: done at %0d, last write at %0d, required gap %0d",
                     end_cyc, wq_cyc.size() > 0 ? wq_cyc[wq_cyc.size() - 1] : -1, FULL_END_LAT);
        else n_pass++;
    endtask

    task automatic test_oversize();
        clear_writes();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        n_checks++;
        if (error !== 1'b1 || done !== 1'b0) $display("FAIL oversize_error: error %b done %b, required 1 0", error, done);
        else n_pass++;
        n_checks++;
        if (bus.byte_ready !== 1'b0 || cpu_hold !== 1'b0)
            $display("FAIL oversize_ready: byte_ready %b hold %b, required 0 0", bus.byte_ready, cpu_hold);
        else n_pass++;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (wq_data.size() !== 0) $display("FAIL oversize_writes: %0d writes, required 0", wq_data.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        clear_writes();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (error !== 1'b0) $display("FAIL timeout_early: error %b after 15 idle cycles, required 0", error);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (error !== 1'b1) $display("FAIL timeout_fire: error %b after 16 idle cycles, required 1", error);
        else n_pass++;
        n_checks++;
        if (bus.byte_ready !== 1'b0 || cpu_hold !== 1'b0)
            $display("FAIL timeout_ready: byte_ready %b hold %b, required 0 0", bus.byte_ready, cpu_hold);
        else n_pass++;
        pulse_start();
        n_checks++;
        if (error !== 1'b0 || bus.byte_ready !== 1'b1 || cpu_hold !== 1'b1)
            $display("FAIL restart_hdr0: error %b ready %b hold %b, required 0 1 1", error, bus.byte_ready, cpu_hold);
        else n_pass++;
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if (error !== 1'b0) $display("FAIL hdr0_timeout_early: error %b, required 0", error);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (error !== 1'b1) $display("FAIL hdr0_timeout_fire: error %b, required 1", error);
        else n_pass++;
    endtask

    task automatic test_one_word(input logic [7:0] flip);
        logic [7:0]  pl[$];
        logic [31:0] words[$];
        bit          ok;
        clear_writes();
        pulse_start();
        pl    = '{8'h11, 8'h22, 8'h33, 8'h44};
        words = '{32'h4433_2211};
        send_frame(16'd1, pl, 1'b0, flip);
        wait_end(600, ok);
        n_checks++;
        if (!ok) $display("FAIL one_word_end: no done/error within bound (flip %h)", flip);
        else n_pass++;
        if (flip == 8'h00) begin
            n_checks++;
            if (done !== 1'b1 || error !== 1'b0) $display("FAIL one_word_done: done %b error %b, required 1 0", done, error);
            else n_pass++;
            n_checks++;
            if (wq_data.size() !== DEPTH || img_bad(words) !== 0)
                $display("FAIL one_word_image: %0d writes %0d bad, required %0d writes 0 bad", wq_data.size(), img_bad(words), DEPTH);
            else n_pass++;
        end else begin
            n_checks++;
            if (error !== 1'b1 || done !== 1'b0) $display("FAIL csum_bad_error: error %b done %b, required 1 0", error, done);
            else n_pass++;
            n_checks++;
            if (wq_data.size() !== 1 || wq_data[0] !== 32'h4433_2211)
                $display("FAIL csum_bad_writes: %0d writes first %h, required 1 write 44332211",
                         wq_data.size(), wq_data.size() > 0 ? wq_data[0] : 32'hx);
            else n_pass++;
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        test_reset();
        test_two_words(1'b0);
        test_empty();
        test_full();
        test_oversize();
        test_timeout();
        test_two_words(1'b1);
        test_one_word(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_one_word(8'h01);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
